mdpt_train: RTL

- Training-side producer for the memory dependence prediction table.
- Takes two event streams and turns each into a next MDP value:
  - load-store ordering violations from the load pipeline;
  - commit-time dependence outcomes from the ROB.
- Filters out no-op writes, buffers events in a small FIFO, and drives the table's single update port (update_valid/update_pc38/update_mdp) at one write per cycle.

---
 rtl/mdpt_train.sv | 113 +++++++++++
 1 files changed

// File: rtl/mdpt_train.sv
//----------------------------------------------------------------------------
// mdpt_train: turns load violations and commit outcomes into MDP table writes
// through a small FIFO feeding the table's single update port.  Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module mdpt_train #(
   parameter int QUEUE_DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        viol_valid,
   output logic        viol_ready,
   input  logic [37:0] viol_pc38,
   input  logic [7:0]  viol_old_mdp,
   input  logic [5:0]  viol_store_dist,
   input  logic        commit_valid,
   input  logic [37:0] commit_pc38,
   input  logic [7:0]  commit_old_mdp,
   input  logic        commit_dep_observed,
   output logic        commit_drop,
   output logic        update_valid,
   output logic [37:0] update_pc38,
   output logic [7:0]  update_mdp
);

   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

   logic [37:0]   pc_q  [QUEUE_DEPTH];
   logic [7:0]    mdp_q [QUEUE_DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d, tail_c;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [1:0] v_conf, c_conf;
   logic [5:0] v_dist;
   logic [7:0] viol_new, commit_new;
   logic       viol_enq, commit_need, commit_fit, commit_enq, deq;

   assign v_conf = viol_old_mdp[7:6];
   assign v_dist = viol_old_mdp[5:0];
   assign c_conf = commit_old_mdp[7:6];

   // A repeat violation at the same distance earns full confidence.
   assign viol_new = {((v_conf != 2'd0) && (v_dist == viol_store_dist)) ? 2'd3 : 2'd2,
                      viol_store_dist};

   always_comb begin
      commit_new = commit_old_mdp;
      if (commit_dep_observed) begin
         commit_new[7:6] = (c_conf == 2'd3) ? 2'd3 : c_conf + 2'd1;
      end else if (c_conf == 2'd1) begin
         commit_new = 8'h00;
      end else begin
         commit_new[7:6] = c_conf - 2'd1;
      end
   end

   assign commit_need = commit_valid && (c_conf != 2'd0) && (commit_new != commit_old_mdp);

   // Space is judged on the registered count only; the dequeue this cycle
   // does not make room for an enqueue in the same cycle.
   assign viol_ready  = (cnt_q < DEPTH_C);
   assign viol_enq    = viol_valid && viol_ready && (viol_new != viol_old_mdp);
   assign commit_fit  = ((cnt_q + CW'(viol_enq)) < DEPTH_C);
   assign commit_enq  = commit_need && commit_fit;
   assign commit_drop = commit_need && !commit_fit;
   assign deq         = (cnt_q != '0);

   assign tail_c = tail_q + PW'(viol_enq);
   assign tail_d = tail_q + PW'(viol_enq) + PW'(commit_enq);
   assign head_d = head_q + PW'(deq);
   assign cnt_d  = cnt_q + CW'(viol_enq) + CW'(commit_enq) - CW'(deq);

   assign update_valid = deq;
   assign update_pc38  = deq ? pc_q[head_q]  : 38'd0;
   assign update_mdp   = deq ? mdp_q[head_q] : 8'd0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   // The violation takes the older slot when both events enqueue together.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            pc_q[i]  <= '0;
            mdp_q[i] <= '0;
         end
      end else begin
         if (viol_enq) begin
            pc_q[tail_q]  <= viol_pc38;
            mdp_q[tail_q] <= viol_new;
         end
         if (commit_enq) begin
            pc_q[tail_c]  <= commit_pc38;
            mdp_q[tail_c] <= commit_new;
         end
      end
   end

endmodule

`default_nettype wire
